// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/ack bus between the MEM stage and dmem_ctrl
interface dmem_ctrl_if #(
    parameter int AW = 10
);
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          sign_ext;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack;
    logic          misalign;
    logic          busy;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ack, misalign, busy
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ack, misalign, busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MIPS data memory: byte/half/word access, wait states, alignment check
// Optional power-up clear sweep enabled by defining DMEM_CLEAR_EN.
module dmem_ctrl #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [3:0] WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAITST = 2'd1,
        S_ACCESS = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

`ifdef DMEM_CLEAR_EN
    localparam state_t S_RESET = S_CLEAR;
`else
    localparam state_t S_RESET = S_IDLE;
`endif

    state_t        state;
    state_t        state_nx;
    logic          busy_w;
    logic          accept;
    logic [3:0]    wcnt;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_sext;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;

    logic          misaligned;
    logic [31:0]   rd_word;
    logic [31:0]   ld_val;
    logic [31:0]   st_lane;
    logic [3:0]    st_be;

    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wd;

    logic [31:0]   rdata_q;
    logic          ack_q;
    logic          mis_q;

    logic [31:0]   mem [DEPTH];

`ifdef DMEM_CLEAR_EN
    logic [AW-1:0] clr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == S_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    assign busy_w = (state == S_CLEAR);
`else
    assign busy_w = 1'b0;
`endif

    assign accept = (state == S_IDLE) && bus.req && !busy_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = (WAIT == 0) ? S_ACCESS : S_WAITST;
                end
            end
            S_WAITST: begin
                if (wcnt == WAIT_LAST) begin
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: state_nx = S_IDLE;
            S_CLEAR: begin
`ifdef DMEM_CLEAR_EN
                if (clr_addr == AW'(DEPTH - 1)) begin
                    state_nx = S_IDLE;
                end
`else
                state_nx = S_IDLE;
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Wait-state counter restarts on every accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (accept) begin
            wcnt <= '0;
        end else if (state == S_WAITST) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (accept) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sext  <= bus.sign_ext;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end
    end

    assign misaligned = (r_size == 2'b11) ||
                        ((r_size == 2'b01) && r_addr[0]) ||
                        ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));

    assign rd_word = mem[r_addr[AW+1:2]];

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b      = rd_word[{r_addr[1:0], 3'b000} +: 8];
        h      = r_addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_val = rd_word;
        case (r_size)
            2'b00:   ld_val = {{24{r_sext & b[7]}}, b};
            2'b01:   ld_val = {{16{r_sext & h[15]}}, h};
            default: ld_val = rd_word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target bytes.
    always_comb begin
        st_lane = r_wdata;
        st_be   = 4'b0000;
        case (r_size)
            2'b00: begin
                st_lane = {4{r_wdata[7:0]}};
                st_be   = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                st_lane = {2{r_wdata[15:0]}};
                st_be   = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                st_lane = r_wdata;
                st_be   = 4'b1111;
            end
            default: begin
                st_lane = r_wdata;
                st_be   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = st_be;
        mem_waddr = r_addr[AW+1:2];
        mem_wd    = st_lane;
        if ((state == S_ACCESS) && r_we && !misaligned) begin
            mem_we = 1'b1;
        end
`ifdef DMEM_CLEAR_EN
        if ((state == S_CLEAR) && !rst) begin
            mem_we    = 1'b1;
            mem_be    = 4'b1111;
            mem_waddr = clr_addr;
            mem_wd    = '0;
        end
`endif
    end

    // Storage array has no reset so it maps onto byte-enabled RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= (state == S_ACCESS);
            mis_q <= (state == S_ACCESS) && misaligned;
            if ((state == S_ACCESS) && !r_we && !misaligned) begin
                rdata_q <= ld_val;
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ack      = ack_q;
    assign bus.misalign = mis_q;
    assign bus.busy     = busy_w;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl (WAIT=0 and WAIT=3 instances)
module tb_dmem_ctrl;
    localparam int AW = 4;
    localparam int NB = 4 * (2 ** AW);
    localparam int WA = 0;
    localparam int WB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.AW(AW)) ia ();
    dmem_ctrl_if #(.AW(AW)) ib ();

    dmem_ctrl #(.AW(AW), .WAIT(WA)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    dmem_ctrl #(.AW(AW), .WAIT(WB)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  mdl [2][NB];
    logic [31:0] last_rd [2];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [1:0] sz, input bit sx, input int a);
        logic [15:0] h;
        case (sz)
            2'b00:   return sx ? {{24{mdl[d][a][7]}}, mdl[d][a]} : {24'h0, mdl[d][a]};
            2'b01: begin
                h = {mdl[d][a+1], mdl[d][a]};
                return sx ? {{16{h[15]}}, h} : {16'h0, h};
            end
            default: return {mdl[d][a+3], mdl[d][a+2], mdl[d][a+1], mdl[d][a]};
        endcase
    endfunction

    task automatic drive(input int d, input bit r, input bit w, input logic [1:0] sz,
                         input bit sx, input logic [5:0] a, input logic [31:0] wd);
        if (d == 0) begin
            ia.req = r; ia.we = w; ia.size = sz; ia.sign_ext = sx; ia.addr = a; ia.wdata = wd;
        end else begin
            ib.req = r; ib.we = w; ib.size = sz; ib.sign_ext = sx; ib.addr = a; ib.wdata = wd;
        end
    endtask

    // Reference: byte-addressed little-endian array; one access completes per request.
    task automatic push_expect(input int d, input bit w, input logic [1:0] sz, input bit sx,
                               input logic [5:0] a, input logic [31:0] wd, input int extra);
        exp_t e;
        int   ai;
        bit   mis;
        ai  = int'(a);
        mis = (sz == 2'b11) || (sz == 2'b01 && (ai % 2) != 0) || (sz == 2'b10 && (ai % 4) != 0);
        if (!mis && w) begin
            case (sz)
                2'b00: mdl[d][ai] = wd[7:0];
                2'b01: begin mdl[d][ai] = wd[7:0]; mdl[d][ai+1] = wd[15:8]; end
                default: for (int k = 0; k < 4; k++) mdl[d][ai+k] = wd[8*k +: 8];
            endcase
        end
        if (!mis && !w) last_rd[d] = model_load(d, sz, sx, ai);
        e.mis = mis;
        e.rd  = last_rd[d];
        e.cyc = cyc + 1 + ((d == 0) ? WA : WB) + 1 + extra;
        if (d == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (qsize(d) != 0) begin
            chk("ack_timeout", 32'(qsize(d)), 32'd0);
            if (d == 0) qa.delete(); else qb.delete();
        end
    endtask

    task automatic access(input int d, input bit w, input logic [1:0] sz, input bit sx,
                          input logic [5:0] a, input logic [31:0] wd);
        @(negedge clk);
        drive(d, 1'b1, w, sz, sx, a, wd);
        push_expect(d, w, sz, sx, a, wd, 0);
        @(negedge clk);
        drive(d, 1'b0, w, sz, sx, a, wd);
        wait_drain(d);
    endtask

    task automatic release_reset(input bit poke);
        int n;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
`ifdef DMEM_CLEAR_EN
        while (ia.busy && n < 100) begin
            if (poke && n == 2) drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
            if (n == 10) drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'(2 ** AW));
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NB; i++) mdl[d][i] = 8'h00;
`else
        if (poke) n = 1;
        chk("busy_idle", {31'h0, ia.busy}, 32'd0);
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ia.ack === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_rdata", ia.rdata, e.rd);
                chk("a_misalign", {31'h0, ia.misalign}, {31'h0, e.mis});
                chk("a_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (ib.ack === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_rdata", ib.rdata, e.rd);
                chk("b_misalign", {31'h0, ib.misalign}, {31'h0, e.mis});
                chk("b_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  sz;
        int          r;
        int          a;
        int          d;
        int          c0;
        for (int i = 0; i < NB; i++) begin mdl[0][i] = 8'h00; mdl[1][i] = 8'h00; end
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 6'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 6'h0, 32'h0);
        repeat (3) @(negedge clk);

        chk("rst_ack", {31'h0, ia.ack}, 32'd0);
        chk("rst_misalign", {31'h0, ia.misalign}, 32'd0);
        chk("rst_rdata", ia.rdata, 32'h0);
        chk("rst_rdata_b", ib.rdata, 32'h0);
`ifdef DMEM_CLEAR_EN
        chk("rst_busy", {31'h0, ia.busy}, 32'd1);
`else
        chk("rst_busy", {31'h0, ia.busy}, 32'd0);
`endif
        release_reset(1'b1);

        for (int dd = 0; dd < 2; dd++)
            for (int w = 0; w < 2 ** AW; w++) access(dd, 1'b1, 2'b10, 1'b0, 6'(w * 4), 32'h0);

        // T1
        access(0, 1'b1, 2'b10, 1'b0, 6'h10, 32'hDEADBEEF);
        access(0, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        chk("t1_lw", ia.rdata, 32'hDEADBEEF);
        // T2
        access(0, 1'b1, 2'b00, 1'b0, 6'h11, 32'h00000080);
        access(0, 1'b0, 2'b00, 1'b1, 6'h11, 32'h0);
        chk("t2_lb", ia.rdata, 32'hFFFFFF80);
        access(0, 1'b0, 2'b00, 1'b0, 6'h11, 32'h0);
        chk("t2_lbu", ia.rdata, 32'h00000080);
        access(0, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        chk("t2_lw_sb", ia.rdata, 32'hDEAD80EF);
        access(0, 1'b1, 2'b01, 1'b0, 6'h12, 32'h00001234);
        access(0, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        chk("t2_lw_sh", ia.rdata, 32'h123480EF);
        access(0, 1'b0, 2'b01, 1'b1, 6'h12, 32'h0);
        chk("t2_lh", ia.rdata, 32'h00001234);
        // T3
        access(0, 1'b0, 2'b01, 1'b1, 6'h13, 32'h0);
        access(0, 1'b1, 2'b10, 1'b0, 6'h12, 32'hFFFFFFFF);
        access(0, 1'b0, 2'b11, 1'b0, 6'h10, 32'h0);
        access(0, 1'b1, 2'b11, 1'b0, 6'h10, 32'hFFFFFFFF);
        access(0, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        chk("t3_lw_unchanged", ia.rdata, 32'h123480EF);

        // T4: req held high through ack gives a second access at E0+5
        access(1, 1'b1, 2'b10, 1'b0, 6'h10, 32'h5A5AA5A5);
        @(negedge clk);
        c0 = cyc;
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        push_expect(1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 0);
        push_expect(1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0, WB + 2);
        repeat (WB + 3) @(negedge clk);
        drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
        wait_drain(1);
        chk("t4_rdata", ib.rdata, 32'h5A5AA5A5);
        chk("t4_span", 32'(cyc - c0 >= 2 * (WB + 2)), 32'd1);

        // T5: reset while a store sits in WAITST; the store must vanish
        access(1, 1'b1, 2'b10, 1'b0, 6'h20, 32'hCAFEF00D);
        access(1, 1'b0, 2'b10, 1'b0, 6'h20, 32'h0);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 6'h20, 32'h11111111);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 2'b10, 1'b0, 6'h20, 32'h11111111);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_rdata_a", ia.rdata, 32'h0);
        chk("t5_rdata_b", ib.rdata, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        release_reset(1'b0);
        repeat (8) @(negedge clk);
        access(1, 1'b0, 2'b10, 1'b0, 6'h20, 32'h0);
`ifdef DMEM_CLEAR_EN
        chk("t5_lw_old", ib.rdata, 32'h00000000);
`else
        chk("t5_lw_old", ib.rdata, 32'hCAFEF00D);
`endif

        // Randomised traffic, mostly on the zero-wait instance
        for (int i = 0; i < 200; i++) begin
            d = (i % 4 == 3) ? 1 : 0;
            r = $urandom_range(0, 7);
            sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            a = $urandom_range(0, NB - 1);
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'b01) a = a & ~1;
                if (sz == 2'b10) a = a & ~3;
            end
            access(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 6'(a), $urandom);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
